data_sampling_rx_mv: RTL and testbench
======================================

// Module: data_sampling_rx_mv
// PURPOSE
//  Parametrised UART RX bit sampler with majority vote, the successor to the fixed 3-sample sampler.
//  Resynchronises RX_IN, takes NUM_SAMPLES oversampled reads centred on mid-bit and votes them into one bit.
//  Per bit it produces a 1-cycle valid strobe and a noise flag for non-unanimous or incomplete votes.
//  Sits between the RX edge/bit counter and the deserializer/parity/stop checkers in the UART RX top.
// PARAMETERS
//  PRESCALE_W   6  width of prescale/edge_cnt (max oversampling 2**PRESCALE_W-1)
//  NUM_SAMPLES  3  samples per bit; odd, 1..7
//  SYNC_STAGES  2  RX_IN synchroniser flops, 0..3 (0 = RX_IN used directly)
// PORTS
//  CLK_SAM          in   1            oversampling clock
//  RST_SAM          in   1            synchronous active-low reset
//  RX_IN            in   1            serial line, asynchronous, idle high
//  data_samp_en     in   1            sampling enable from RX FSM
//  edge_cnt         in   PRESCALE_W   oversample edge index within current bit, 0..prescale-1
//  prescale         in   PRESCALE_W   oversampling ratio, static while enabled
//  sample_bit_samp  out  1            voted bit, held until next decision
//  sample_valid     out  1            1-cycle strobe: sample_bit_samp updated this cycle
//  noise_err        out  1            last vote non-unanimous or incomplete, held with bit
//  cfg_err          out  1            registered: prescale illegal for NUM_SAMPLES
// BEHAVIOUR
//  Reset (RST_SAM=0 at CLK_SAM edge): sync chain all 1, sample_bit_samp=1, sample_valid=0,
//   noise_err=0, cfg_err=0, ones_cnt=0, samp_cnt=0.
//  Synchroniser: shift chain clocked every cycle regardless of enable; rx_s = last stage.
//   Sample point is thus SYNC_STAGES cycles after line; edge_cnt window not compensated.
//  Derived: C = prescale>>1; H = (NUM_SAMPLES-1)/2; window = edge_cnt in [C-H, C+H];
//   decision edge D = prescale-2.
//  Legal config: C >= H and C+H < D (i.e. no window/decision overlap). cfg_err = !legal,
//   updated every cycle; when cfg_err=1 and enabled, no samples taken, sample_bit_samp=1,
//   noise_err=1 at each D, sample_valid still pulses at D (no lock-up).
//  Enabled, edge_cnt in window: samp_cnt += 1 (saturate at NUM_SAMPLES); ones_cnt += rx_s.
//   One sample per cycle the condition holds; edge_cnt assumed to advance each cycle.
//  Enabled, edge_cnt == D: sample_bit_samp <= (ones_cnt > H); sample_valid <= 1;
//   noise_err <= (samp_cnt != NUM_SAMPLES) | (ones_cnt != 0 & ones_cnt != samp_cnt);
//   ones_cnt, samp_cnt <= 0. Latency: result registered on the cycle edge_cnt==D is seen.
//  All other enabled cycles: sample_valid <= 0; bit and noise_err hold.
//  data_samp_en=0: sample_bit_samp <= 1, sample_valid <= 0, noise_err <= 0, counters <= 0.
//   Disable mid-window discards partial vote; re-enable starts a fresh vote.
//  Enable asserted mid-bit (after window start): partial vote taken, noise_err=1 at D.
//  ones_cnt/samp_cnt width = clog2(NUM_SAMPLES+1); C, D computed at PRESCALE_W+1 bits,
//   no wrap (prescale<2 is illegal -> cfg_err).
//  NUM_SAMPLES=1: single centre sample, noise_err only flags missed sample.
// TESTING
//  prescale=8,N=3,SYNC=0, RX_IN=0 steady, en=1 -> at edge_cnt=6: bit=0, valid=1 one cycle, noise=0.
//  prescale=16,N=5, RX_IN high except edge 8 low -> at edge 14: bit=1, noise_err=1.
//  prescale=16,N=5, RX_IN low at edges 6,7,9 -> bit=0, noise_err=1; next clean bit clears noise.
//  SYNC=2, prescale=8: RX_IN toggles at edge 2 -> vote reflects value delayed 2 cycles.
//  en drop at edge_cnt=4 (prescale=8,N=3), re-enable at next edge 0 -> prior samples discarded,
//   bit=1/noise=0 while disabled; next vote clean.
//  prescale=4,N=3 -> cfg_err=1, valid pulses at edge 2 with bit=1, noise=1; reset mid-vote -> all reset values.

Source files
------------

// File: rtl/data_sampling_rx_mv_if.sv
// data_sampling_rx_mv_if: serial line, sampling controls and voted-bit results of the RX sampler
interface data_sampling_rx_mv_if #(parameter int PRESCALE_W = 6);
  logic                  RX_IN;
  logic                  data_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] prescale;
  logic                  sample_bit_samp;
  logic                  sample_valid;
  logic                  noise_err;
  logic                  cfg_err;
  modport master (output RX_IN, data_samp_en, edge_cnt, prescale,
                  input  sample_bit_samp, sample_valid, noise_err, cfg_err);
  modport slave  (input  RX_IN, data_samp_en, edge_cnt, prescale,
                  output sample_bit_samp, sample_valid, noise_err, cfg_err);
endinterface

// File: rtl/data_sampling_rx_mv.sv
// data_sampling_rx_mv: UART RX bit sampler voting NUM_SAMPLES mid-bit reads into one bit
module data_sampling_rx_mv #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK_SAM,
  input logic RST_SAM,
  data_sampling_rx_mv_if.slave bus
);
  localparam int H  = (NUM_SAMPLES - 1) / 2;
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam int PW = PRESCALE_W + 1;
  localparam logic [PW-1:0] HW  = PW'(H);
  localparam logic [PW-1:0] TWO = PW'(2);
  localparam logic [CW-1:0] NS  = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0] HC  = CW'(H);
  logic          rx_s, legal, in_win, at_d;
  logic [PW-1:0] p, c, d, e;
  logic [CW-1:0] ones_cnt, samp_cnt;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign rx_s = bus.RX_IN;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge CLK_SAM)
      sync <= !RST_SAM ? '1 : SYNC_STAGES'({sync, bus.RX_IN});
    assign rx_s = sync[SYNC_STAGES-1];
  end
  // Centre, decision edge and window are widened by one bit so C+H and prescale-2 never wrap
  always_comb begin
    p      = {1'b0, bus.prescale};
    e      = {1'b0, bus.edge_cnt};
    c      = p >> 1;
    d      = p - TWO;
    legal  = (p >= TWO) && (c >= HW) && (c + HW < d);
    in_win = legal && (e >= c - HW) && (e <= c + HW);
    at_d   = e == d;
  end
  always_ff @(posedge CLK_SAM) begin
    if (!RST_SAM) begin
      bus.sample_bit_samp <= 1'b1;
      bus.sample_valid    <= 1'b0;
      bus.noise_err       <= 1'b0;
      bus.cfg_err         <= 1'b0;
      ones_cnt            <= '0;
      samp_cnt            <= '0;
    end else begin
      bus.cfg_err <= !legal;
      if (!bus.data_samp_en) begin
        bus.sample_bit_samp <= 1'b1;
        bus.sample_valid    <= 1'b0;
        bus.noise_err       <= 1'b0;
        ones_cnt            <= '0;
        samp_cnt            <= '0;
      end else if (at_d) begin
        bus.sample_bit_samp <= legal ? (ones_cnt > HC) : 1'b1;
        bus.sample_valid    <= 1'b1;
        bus.noise_err       <= !legal || (samp_cnt != NS) || (ones_cnt != '0 && ones_cnt != samp_cnt);
        ones_cnt            <= '0;
        samp_cnt            <= '0;
      end else begin
        bus.sample_valid <= 1'b0;
        if (in_win && samp_cnt != NS) begin
          samp_cnt <= samp_cnt + CW'(1);
          ones_cnt <= ones_cnt + CW'(rx_s);
        end
      end
    end
  end
endmodule

// File: tb/tb_data_sampling_rx_mv.sv
// tb_data_sampling_rx_mv: scoreboard bench for two sampler configurations (N=3/SYNC=2, N=5/SYNC=0)
module tb_data_sampling_rx_mv;
  typedef struct { logic b; logic n; logic [5:0] d; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q3[$];
  exp_t q5[$];
  data_sampling_rx_mv_if #(.PRESCALE_W(6)) i3 ();
  data_sampling_rx_mv_if #(.PRESCALE_W(6)) i5 ();
  data_sampling_rx_mv #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) u3 (.CLK_SAM(clk), .RST_SAM(rst), .bus(i3));
  data_sampling_rx_mv #(.PRESCALE_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(0)) u5 (.CLK_SAM(clk), .RST_SAM(rst), .bus(i5));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic drive_bit(input int which, input int ps, input logic [15:0] line,
                           input logic [15:0] en, input logic push, input logic eb, input logic en_n);
    exp_t x;
    x.b = eb; x.n = en_n; x.d = 6'(ps - 2);
    if (push) begin
      if (which == 3) q3.push_back(x); else q5.push_back(x);
    end
    for (int e = 0; e < ps; e++) begin
      @(negedge clk);
      if (which == 3) begin
        i3.edge_cnt = 6'(e); i3.RX_IN = line[e]; i3.data_samp_en = en[e];
      end else begin
        i5.edge_cnt = 6'(e); i5.RX_IN = line[e]; i5.data_samp_en = en[e];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i3.data_samp_en = 1'b0; i5.data_samp_en = 1'b0;
    end
  endtask

  // Monitors: every valid strobe must match the oldest outstanding expectation
  initial forever begin
    exp_t x;
    @(posedge clk); #1;
    if (i3.sample_valid) begin
      if (q3.size() == 0) chk("u3_unexpected_valid", 1, 0);
      else begin
        x = q3.pop_front();
        chk("u3_bit", int'(i3.sample_bit_samp), int'(x.b));
        chk("u3_noise", int'(i3.noise_err), int'(x.n));
        chk("u3_valid_edge", int'(i3.edge_cnt), int'(x.d));
      end
    end
    if (i5.sample_valid) begin
      if (q5.size() == 0) chk("u5_unexpected_valid", 1, 0);
      else begin
        x = q5.pop_front();
        chk("u5_bit", int'(i5.sample_bit_samp), int'(x.b));
        chk("u5_noise", int'(i5.noise_err), int'(x.n));
        chk("u5_valid_edge", int'(i5.edge_cnt), int'(x.d));
      end
    end
  end

  initial begin
    i3.RX_IN = 1'b1; i3.data_samp_en = 1'b0; i3.edge_cnt = '0; i3.prescale = 6'd8;
    i5.RX_IN = 1'b1; i5.data_samp_en = 1'b0; i5.edge_cnt = '0; i5.prescale = 6'd16;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit", int'(i3.sample_bit_samp), 1);
    chk("rst_valid", int'(i3.sample_valid), 0);
    chk("rst_noise", int'(i3.noise_err), 0);
    chk("rst_cfg", int'(i3.cfg_err), 0);
    @(negedge clk); rst = 1'b1;
    idle(3);
    chk("cfg_ok_p8", int'(i3.cfg_err), 0);
    chk("cfg_ok_p16", int'(i5.cfg_err), 0);
    // N=3, two-stage synchroniser, prescale 8: window 3..5, decision at 6
    drive_bit(3, 8, 16'h0000, 16'hFFFF, 1, 0, 0);
    drive_bit(3, 8, 16'h0000, 16'hFFFF, 1, 0, 0);
    drive_bit(3, 8, 16'hFFFF, 16'hFFFF, 1, 1, 0);
    drive_bit(3, 8, 16'hFF03, 16'hFFFF, 1, 0, 1);
    drive_bit(3, 8, 16'h0000, 16'h000F, 0, 0, 0);
    chk("dis_bit", int'(i3.sample_bit_samp), 1);
    chk("dis_noise", int'(i3.noise_err), 0);
    chk("dis_valid", int'(i3.sample_valid), 0);
    drive_bit(3, 8, 16'h0000, 16'hFFFF, 1, 0, 0);
    drive_bit(3, 8, 16'h0000, 16'hFFF0, 1, 0, 1);
    // prescale 4 puts the window over the decision edge
    idle(1); i3.prescale = 6'd4; idle(3);
    chk("cfg_err_p4", int'(i3.cfg_err), 1);
    drive_bit(3, 4, 16'h0000, 16'hFFFF, 1, 1, 1);
    drive_bit(3, 4, 16'h0000, 16'hFFFF, 1, 1, 1);
    idle(1); i3.prescale = 6'd1; idle(3);
    chk("cfg_err_p1", int'(i3.cfg_err), 1);
    i3.prescale = 6'd8; idle(3);
    chk("cfg_clear_p8", int'(i3.cfg_err), 0);
    // N=5, no synchroniser, prescale 16: window 6..10, decision at 14
    drive_bit(5, 16, 16'hFEFF, 16'hFFFF, 1, 1, 1);
    drive_bit(5, 16, 16'hFD3F, 16'hFFFF, 1, 0, 1);
    drive_bit(5, 16, 16'hFFFF, 16'hFFFF, 1, 1, 0);
    drive_bit(5, 16, 16'h0000, 16'hFFFF, 1, 0, 0);
    idle(2);
    // Reset in the middle of a vote after a noisy zero bit
    drive_bit(3, 8, 16'h0000, 16'hFFF0, 1, 0, 1);
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      i3.edge_cnt = 6'(e); i3.RX_IN = 1'b1; i3.data_samp_en = 1'b1;
    end
    @(negedge clk); rst = 1'b0; i3.edge_cnt = 6'd5;
    @(posedge clk); #1;
    chk("midrst_bit", int'(i3.sample_bit_samp), 1);
    chk("midrst_noise", int'(i3.noise_err), 0);
    chk("midrst_valid", int'(i3.sample_valid), 0);
    chk("midrst_cfg", int'(i3.cfg_err), 0);
    @(negedge clk); i3.data_samp_en = 1'b0; rst = 1'b1;
    idle(2);
    drive_bit(3, 8, 16'h0000, 16'hFFFF, 1, 0, 0);
    idle(4);
    chk("u3_queue_drained", q3.size(), 0);
    chk("u5_queue_drained", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
